// File: rtl/hazard_stall_ctrl.sv
// Pipeline interlock: same-cycle Tuse/Tnew data stalls plus mult/div busy sequencing.
// Optional perf counters (data_stall_cnt, md_stall_cnt) under `HAZARD_PERF_EN`.
module hazard_stall_ctrl #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10,
   parameter int CW          = $clog2(((DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES) + 1)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [4:0]    A1_ID,
   input  logic [4:0]    A2_ID,
   input  logic [1:0]    Tuse_rs,
   input  logic [1:0]    Tuse_rt,
   input  logic [4:0]    A3_EX,
   input  logic [4:0]    A3_MEM,
   input  logic [1:0]    Tnew_EX,
   input  logic [1:0]    Tnew_MEM,
   input  logic          md_start_ID,
   input  logic          md_is_div_ID,
   input  logic          md_use_ID,
   input  logic          ext_hold,
   input  logic          md_cancel,
   output logic          stall,
   output logic          idex_clr,
   output logic          md_busy,
   output logic [CW-1:0] md_count
`ifdef HAZARD_PERF_EN
   ,
   output logic [31:0]   data_stall_cnt,
   output logic [31:0]   md_stall_cnt
`endif
);

   logic          stall_rs;
   logic          stall_rt;
   logic          md_stall;
   logic          issue;
   logic [CW-1:0] md_count_q;
   logic [CW-1:0] md_count_d;

   // A producer blocks only while its result arrives later than the consumer needs it.
   always_comb begin
      stall_rs = (A1_ID != 5'd0) &&
                 (((A1_ID == A3_EX)  && (Tnew_EX  > Tuse_rs)) ||
                  ((A1_ID == A3_MEM) && (Tnew_MEM > Tuse_rs)));
      stall_rt = (A2_ID != 5'd0) &&
                 (((A2_ID == A3_EX)  && (Tnew_EX  > Tuse_rt)) ||
                  ((A2_ID == A3_MEM) && (Tnew_MEM > Tuse_rt)));
      md_stall = md_busy && (md_start_ID || md_use_ID);
      stall    = stall_rs || stall_rt || md_stall;
      idex_clr = stall && !ext_hold;
      issue    = md_start_ID && !stall && !ext_hold;
   end

   // The unit keeps counting through ext_hold; cancel beats a same-cycle issue.
   always_comb begin
      md_count_d = md_count_q;
      if (md_cancel) begin
         md_count_d = '0;
      end else if (issue) begin
         md_count_d = md_is_div_ID ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
      end else if (md_count_q != '0) begin
         md_count_d = md_count_q - CW'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         md_count_q <= '0;
      end else begin
         md_count_q <= md_count_d;
      end
   end

   assign md_busy  = (md_count_q != '0);
   assign md_count = md_count_q;

`ifdef HAZARD_PERF_EN
   logic [31:0] data_stall_cnt_q;
   logic [31:0] data_stall_cnt_d;
   logic [31:0] md_stall_cnt_q;
   logic [31:0] md_stall_cnt_d;

   // Saturating; an md stall is attributed only when no data hazard explains the cycle.
   always_comb begin
      data_stall_cnt_d = data_stall_cnt_q;
      md_stall_cnt_d   = md_stall_cnt_q;
      if ((stall_rs || stall_rt) && !ext_hold && (data_stall_cnt_q != 32'hFFFF_FFFF)) begin
         data_stall_cnt_d = data_stall_cnt_q + 32'd1;
      end
      if (md_stall && !stall_rs && !stall_rt && !ext_hold && (md_stall_cnt_q != 32'hFFFF_FFFF)) begin
         md_stall_cnt_d = md_stall_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         data_stall_cnt_q <= '0;
         md_stall_cnt_q   <= '0;
      end else begin
         data_stall_cnt_q <= data_stall_cnt_d;
         md_stall_cnt_q   <= md_stall_cnt_d;
      end
   end

   assign data_stall_cnt = data_stall_cnt_q;
   assign md_stall_cnt   = md_stall_cnt_q;
`endif

endmodule
